// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM with a mem_ready handshake watchdog.
// Optional ILLEGAL_TRAP_EN: illegal opcodes trap to the exception vector and pulse illegal_op.
module mips_mc_control #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [5:0] alu_funct,
  output logic       mem_timeout,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD = 4'd3,
    MEMWB    = 4'd4,  MEMWR   = 4'd5,  RTYPE_EX = 4'd6, RTYPE_WB = 4'd7,
    BEQ_EX   = 4'd8,  JUMP    = 4'd9,  ADDI_EX = 4'd10, LOGI_EX = 4'd11,
    IWB      = 4'd12, ILLEGAL = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);
  localparam bit              WD_EN  = (TIMEOUT_CYCLES != 0);

  state_t            state, state_next;
  logic [TO_W-1:0]   cnt, cnt_next, cnt_inc;
  logic              timeout_reg, timeout_set, wait_st;

  always_comb begin
    state_next  = state;
    timeout_set = 1'b0;
    cnt_next    = '0;
    cnt_inc     = cnt + 1'b1;
    wait_st     = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    case (state)
      FETCH:   if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                       state_next = MEMADR;
          OP_R:                               state_next = RTYPE_EX;
          OP_BEQ:                             state_next = BEQ_EX;
          OP_J:                               state_next = JUMP;
          OP_ADDI:                            state_next = ADDI_EX;
          OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:  state_next = LOGI_EX;
          default:                            state_next = ILLEGAL;
        endcase
      end
      MEMADR:   state_next = (opcode == OP_LW) ? MEMRD :
                             (opcode == OP_SW) ? MEMWR : FETCH;
      MEMRD:    if (mem_ready) state_next = MEMWB;
      MEMWR:    if (mem_ready) state_next = FETCH;
      RTYPE_EX: state_next = RTYPE_WB;
      ADDI_EX,
      LOGI_EX:  state_next = IWB;
      default:  state_next = FETCH;
    endcase
    // Counter only runs while stalled in a wait state; any other cycle (including entry) clears it.
    if (wait_st && !mem_ready) begin
      if (WD_EN && (cnt_inc == TO_LIM)) begin
        timeout_set = 1'b1;
        state_next  = FETCH;
      end else begin
        cnt_next = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      cnt         <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (timeout_set) timeout_reg <= 1'b1;
    end
  end

  assign mem_timeout = timeout_reg;
  assign state_dbg   = state;

  always_comb begin
    pc_write = 1'b0; pc_write_cond = 1'b0; iord = 1'b0; mem_read = 1'b0;
    mem_write = 1'b0; ir_write = 1'b0; reg_dst = 1'b0; mem_to_reg = 1'b0;
    reg_write = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00; pc_source = 2'b00;
    alu_op = 2'b00; alu_funct = funct;
`ifdef ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif
    case (state)
      FETCH:    begin mem_read = 1'b1; alu_src_b = 2'b01; ir_write = mem_ready; pc_write = mem_ready; end
      DECODE:   alu_src_b = 2'b11;
      MEMADR:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      MEMRD:    begin mem_read = 1'b1; iord = 1'b1; end
      MEMWB:    begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      MEMWR:    begin mem_write = 1'b1; iord = 1'b1; end
      RTYPE_EX: begin alu_src_a = 1'b1; alu_op = 2'b10; end
      RTYPE_WB: begin reg_write = 1'b1; reg_dst = 1'b1; end
      BEQ_EX:   begin alu_src_a = 1'b1; alu_op = 2'b01; pc_write_cond = 1'b1; pc_source = 2'b01; end
      JUMP:     begin pc_write = 1'b1; pc_source = 2'b10; end
      ADDI_EX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      LOGI_EX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = 2'b11; alu_funct = {2'b00, opcode[3:0]}; end
      IWB:      reg_write = 1'b1;
      ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        pc_write = 1'b1; pc_source = 2'b11; illegal_op = 1'b1;
`endif
      end
      default: ;
    endcase
    // Nothing may be requested of the datapath while reset is held.
    if (!rst_n) begin
      pc_write = 1'b0; pc_write_cond = 1'b0; iord = 1'b0; mem_read = 1'b0;
      mem_write = 1'b0; ir_write = 1'b0; reg_dst = 1'b0; mem_to_reg = 1'b0;
      reg_write = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00; pc_source = 2'b00;
      alu_op = 2'b00; alu_funct = 6'b000000;
`ifdef ILLEGAL_TRAP_EN
      illegal_op = 1'b0;
`endif
    end
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle MIPS main control FSM; the producer side of the alu_op/funct interface consumed by ALU_Control.
- Decodes the instruction-register opcode and drives datapath enables, mux selects, alu_op[1:0] and alu_funct[5:0] state by state.
- Memory accesses use a ready handshake with a watchdog timeout.
- Sits between the instruction register and the datapath/ALU_Control in the multi-cycle core variant.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ready before timeout; 0 disables the watchdog.
- TO_W, 8: width of the wait counter; must satisfy TIMEOUT_CYCLES < 2^TO_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from the IR.
- funct  in  6  instr[5:0] from the IR.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- alu_op  out  2  to ALU_Control: 00 add, 01 sub, 10 R-type, 11 I-type logical.
- alu_funct  out  6  to ALU_Control funct input.
- mem_timeout  out  1  sticky watchdog flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (async, rst_n = 0):
  - State = FETCH, wait counter = 0, mem_timeout = 0.
  - All enables are 0 while reset is asserted; selects are 0.
  - On release, FETCH outputs appear in the first cycle.
- All outputs are decoded from the registered state. The only combinational qualifier is mem_ready, as noted below.
- Default output values in every state: all enables 0, all selects 00/0, alu_op = 00, alu_funct = funct.
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, addi = 001000, andi = 001100, ori = 001101, xori = 001110, slti = 001010.
- State encodings (0-12):
  - 0 FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00. ir_write and pc_write equal mem_ready. Advance to DECODE when mem_ready = 1, else hold.
  - 1 DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00. Dispatch on opcode: lw/sw → MEMADR; R → RTYPE_EX; beq → BEQ_EX; j → JUMP; addi → ADDI_EX; andi/ori/xori/slti → LOGI_EX; any other opcode → ILLEGAL.
  - 2 MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to MEMRD if lw, MEMWR if sw.
  - 3 MEMRD: mem_read = 1, iord = 1. Advance to MEMWB on mem_ready.
  - 4 MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0 → FETCH.
  - 5 MEMWR: mem_write = 1, iord = 1. Go to FETCH on mem_ready.
  - 6 RTYPE_EX: alu_src_a = 1, alu_src_b = 00, alu_op = 10, alu_funct = funct → RTYPE_WB.
  - 7 RTYPE_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0 → FETCH.
  - 8 BEQ_EX: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01 → FETCH.
  - 9 JUMP: pc_write = 1, pc_source = 10 → FETCH.
  - 10 ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 00 → IWB.
  - 11 LOGI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 11, alu_funct = {2'b00, opcode[3:0]} → IWB.
  - 12 IWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0 → FETCH.
- ILLEGAL: behaviour defined under Optional Feature.
- Watchdog:
  - Counter clears on entry to FETCH, MEMRD or MEMWR, and on any cycle with mem_ready = 1.
  - Increments each waiting cycle with mem_ready = 0.
  - When counter == TIMEOUT_CYCLES (TIMEOUT_CYCLES ≠ 0): set mem_timeout, abandon the access, next state = FETCH, counter = 0.
  - mem_timeout clears only on reset.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- mem_ready = 1 on the first cycle of a wait state completes that access in one cycle.
- Reset asserted mid-instruction aborts it immediately; no partial writes are issued after reset asserts.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - ILLEGAL state asserts pc_write = 1 and pc_source = 11 for one cycle, then returns to FETCH.
  - Output illegal_op (1 bit, added port) pulses high in that cycle.
- ILLEGAL_TRAP_EN undefined:
  - ILLEGAL state issues no writes (NOP), then returns to FETCH.
  - The illegal_op port is absent.

Test Plan:
- lw (opcode 100011), mem_ready high after 2 wait cycles in FETCH and 1 in MEMRD → state sequence 0,0,0,1,2,3,3,4,0; reg_write = 1 and mem_to_reg = 1 only in state 4.
- R-type sub (funct 100010) → alu_op = 10 and alu_funct = 100010 in RTYPE_EX; reg_write = 1 and reg_dst = 1 next cycle.
- ori (opcode 001101) → LOGI_EX drives alu_op = 11, alu_funct = 001101; IWB drives reg_write = 1, reg_dst = 0.
- beq → BEQ_EX drives alu_op = 01, pc_write_cond = 1, pc_source = 01. j → pc_write = 1, pc_source = 10. Each takes 3 states total.
- TIMEOUT_CYCLES = 4, mem_ready held 0 in MEMWR → mem_timeout rises after 4 waiting cycles; FSM returns to FETCH and mem_timeout stays 1 until rst_n = 0.
- Opcode 111111 with ILLEGAL_TRAP_EN → pc_source = 11, pc_write = 1, illegal_op = 1 for one cycle. Without the macro → no enables asserted, back to FETCH. Also drop rst_n during MEMWR → mem_write = 0 immediately and state_dbg = 0.
